// File: rtl/mul_share_arbiter.sv
// Round-robin share of one external combinational W x W multiplier between two
// requesters; operands and product are registered, results return tagged with the requester.
module mul_share_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*W-1:0]   res_p,
    output logic             res_id,
    output logic             busy,
    output logic [CNT_W-1:0] ops_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [W-1:0]       mul_a_q, mul_a_d;
    logic [W-1:0]       mul_b_q, mul_b_d;
    logic [2*W-1:0]     res_p_q, res_p_d;
    logic               res_id_q, res_id_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   ops_count_q, ops_count_d;

    logic               grant_vld_s;
    logic               grant_s;

    // Arbitration: a tie goes to the requester that did not win last time.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
        if ((state_q == ST_IDLE) && ena) begin
            case (req_valid)
                2'b01: begin
                    grant_vld_s = 1'b1;
                    grant_s     = 1'b0;
                end
                2'b10: begin
                    grant_vld_s = 1'b1;
                    grant_s     = 1'b1;
                end
                2'b11: begin
                    grant_vld_s = 1'b1;
                    grant_s     = ~last_grant_q;
                end
                default: begin
                    grant_vld_s = 1'b0;
                    grant_s     = 1'b0;
                end
            endcase
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
        end
    end

    // Next-state and datapath updates for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        res_p_d      = res_p_q;
        res_id_d     = res_id_q;
        res_valid_d  = res_valid_q;
        ops_count_d  = ops_count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    mul_a_d      = grant_s ? req1_a : req0_a;
                    mul_b_d      = grant_s ? req1_b : req0_b;
                    res_id_d     = grant_s;
                    last_grant_d = grant_s;
                    state_d      = ST_CALC;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_CALC: begin
                res_p_d     = mul_p;
                res_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    ops_count_d = ops_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            res_p_q      <= '0;
            res_id_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ops_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            res_p_q      <= res_p_d;
            res_id_q     <= res_id_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            ops_count_q  <= ops_count_d;
        end
    end

    assign req_ready = grant_vld_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_p     = res_p_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign ops_count = ops_count_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: a timestamp-based transaction model is
// compared every cycle, and hand-computed literals pin the model at key points.
module tb_mul_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_p;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_p;
    logic       res_id;
    logic       busy;
    logic [7:0] ops_count;

    int checks = 0;
    int errors = 0;

    mul_share_arbiter #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_p(res_p), .res_id(res_id), .busy(busy), .ops_count(ops_count)
    );

    // The shared multiplier lives outside the arbiter.
    assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction in flight, timed from its grant cycle.
    bit m_inflight;
    int m_cyc, m_gcyc, m_last, m_ops, m_mul_a, m_mul_b, m_res_p, m_res_id;

    always @(negedge clk) begin
        int g;
        int exp_ready;
        bit exp_rv;
        if (!rst_n) begin
            m_inflight = 0; m_cyc = 0; m_gcyc = 0; m_last = 1; m_ops = 0;
            m_mul_a = 0; m_mul_b = 0; m_res_p = 0; m_res_id = 0;
        end
        g = 0;
        exp_ready = 0;
        if (!m_inflight && ena && req_valid != 2'b00) begin
            if (req_valid == 2'b11) g = 1 - m_last;
            else g = req_valid[1] ? 1 : 0;
            exp_ready = 1 << g;
        end
        exp_rv = m_inflight && (m_cyc >= m_gcyc + 2);
        chk("m_req_ready", int'(req_ready), exp_ready);
        chk("m_busy", int'(busy), int'(m_inflight));
        chk("m_res_valid", int'(res_valid), int'(exp_rv));
        chk("m_mul_a", int'(mul_a), m_mul_a);
        chk("m_mul_b", int'(mul_b), m_mul_b);
        chk("m_res_p", int'(res_p), m_res_p);
        chk("m_res_id", int'(res_id), m_res_id);
        chk("m_ops_count", int'(ops_count), m_ops % 256);
        if (rst_n) begin
            if (exp_ready != 0) begin
                m_inflight = 1; m_gcyc = m_cyc; m_last = g; m_res_id = g;
                m_mul_a = g ? int'(req1_a) : int'(req0_a);
                m_mul_b = g ? int'(req1_b) : int'(req0_b);
            end else if (m_inflight && m_cyc == m_gcyc + 1) begin
                m_res_p = m_mul_a * m_mul_b;
            end else if (exp_rv && res_ready) begin
                m_inflight = 0;
                m_ops++;
            end
            m_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input logic id, input logic [3:0] a, input logic [3:0] b);
        if (id) begin req1_a = a; req1_b = b; req_valid = 2'b10; end
        else begin req0_a = a; req0_b = b; req_valid = 2'b01; end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
        req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
        tick(); tick();
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 0: 3*5.
        req0_a = 4'd3; req0_b = 4'd5; req_valid = 2'b01;
        #1 chk("t1_ready", int'(req_ready), 1);
        tick();
        req_valid = 2'b00;
        #1 chk("t1_mul_a", int'(mul_a), 3);
        chk("t1_mul_b", int'(mul_b), 5);
        tick();
        #1 chk("t1_res_valid", int'(res_valid), 1);
        chk("t1_res_p", int'(res_p), 15);
        chk("t1_res_id", int'(res_id), 0);
        tick();
        #1 chk("t1_ops", int'(ops_count), 1);

        // Requester 1 alone: 12*11.
        single_op(1'b1, 4'd12, 4'd11);
        #1 chk("t1b_res_p", int'(res_p), 132);
        chk("t1b_ops", int'(ops_count), 2);

        // Both valid continuously: grants 0,1,0.
        req0_a = 4'd7; req0_b = 4'd9; req1_a = 4'd15; req1_b = 4'd15;
        req_valid = 2'b11;
        #1 chk("t2_g0", int'(req_ready), 1);
        tick(); tick();
        #1 chk("t2_p0", int'(res_p), 63);
        chk("t2_id0", int'(res_id), 0);
        tick();
        #1 chk("t2_g1", int'(req_ready), 2);
        tick(); tick();
        #1 chk("t2_p1", int'(res_p), 225);
        chk("t2_id1", int'(res_id), 1);
        tick();
        #1 chk("t2_g2", int'(req_ready), 1);
        tick();
        req_valid = 2'b00;
        tick();
        #1 chk("t2_p2", int'(res_p), 63);
        chk("t2_id2", int'(res_id), 0);
        tick();
        #1 chk("t2_ops", int'(ops_count), 5);

        // Backpressure on a 15*15 result.
        req_valid = 2'b10; res_ready = 1'b0;
        #1 chk("t3_ready", int'(req_ready), 2);
        tick();
        req_valid = 2'b00;
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_hold_valid", int'(res_valid), 1);
            chk("t3_hold_p", int'(res_p), 225);
            chk("t3_hold_id", int'(res_id), 1);
            chk("t3_hold_ready", int'(req_ready), 0);
            chk("t3_hold_ops", int'(ops_count), 5);
            tick();
        end
        req_valid = 2'b00; res_ready = 1'b1;
        #1 chk("t3_pre_accept", int'(res_valid), 1);
        tick();
        #1 chk("t3_ops", int'(ops_count), 6);
        chk("t3_res_valid", int'(res_valid), 0);

        // ena gating: no grant while low; in-flight work completes anyway.
        ena = 1'b0; req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_no_grant", int'(req_ready), 0);
            chk("t4_idle", int'(busy), 0);
            tick();
        end
        ena = 1'b1;
        #1 chk("t4_grant0", int'(req_ready), 1);
        tick();
        ena = 1'b0; req_valid = 2'b10;
        #1 chk("t4_busy", int'(busy), 1);
        tick();
        #1 chk("t4_res_valid", int'(res_valid), 1);
        chk("t4_res_p", int'(res_p), 63);
        tick();
        #1 chk("t4_blocked0", int'(req_ready), 0);
        chk("t4_busy0", int'(busy), 0);
        tick();
        #1 chk("t4_blocked1", int'(req_ready), 0);
        ena = 1'b1;
        #1 chk("t4_grant1", int'(req_ready), 2);
        tick();
        req_valid = 2'b00;
        tick();
        #1 chk("t4_res_p1", int'(res_p), 225);
        chk("t4_res_id1", int'(res_id), 1);
        tick();
        #1 chk("t4_ops", int'(ops_count), 8);

        // Asynchronous reset during CALC.
        req0_a = 4'd3; req0_b = 4'd5; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1 chk("t5_res_valid", int'(res_valid), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_mul_a", int'(mul_a), 0);
        chk("t5_mul_b", int'(mul_b), 0);
        chk("t5_ops", int'(ops_count), 0);
        tick();
        req0_a = 4'd7; req0_b = 4'd9; req_valid = 2'b11;
        tick();
        rst_n = 1'b1;
        #1 chk("t5_first_grant", int'(req_ready), 1);
        tick();
        req_valid = 2'b00;
        tick();
        #1 chk("t5_res_p", int'(res_p), 63);
        chk("t5_res_id", int'(res_id), 0);
        tick();
        #1 chk("t5_ops1", int'(ops_count), 1);

        // Counter wrap: 255 more accepted operations take it from 1 through 255 to 0.
        for (int i = 0; i < 254; i++) begin
            single_op(1'(i % 2), 4'(i % 16), 4'((i * 7) % 16));
        end
        #1 chk("t6_ops255", int'(ops_count), 255);
        single_op(1'b0, 4'd2, 4'd2);
        #1 chk("t6_wrap", int'(ops_count), 0);
        chk("t6_res_p", int'(res_p), 4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational 4x4 array multiplier between two requesters.
- Round-robin arbitration between the requesters.
- Registers the operands into the multiplier, captures the product and returns it with a requester tag over a valid/ready handshake.
- Sits between the requester logic and the multiplier instance; the multiplier stays purely combinational outside this block.

Parameters:
- W, 4, operand width; product width is 2*W.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; gates new grants only
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept, one-hot or zero
- req0_a, req0_b  in  W each  requester 0 operands
- req1_a, req1_b  in  W each  requester 1 operands
- mul_a, mul_b  out  W each  registered operands to the multiplier
- mul_p  in  2W  product from the multiplier
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_p  out  2W  registered product
- res_id  out  1  requester that issued the result
- busy  out  1  high whenever state is not IDLE
- ops_count  out  CNT_W  completed results, wraps

Behaviour:
- One clock. Reset is asynchronous and active-low: the clock is clk, the reset is rst_n.
- Reset values:
  - state = IDLE
  - mul_a = mul_b = 0
  - res_p = 0, res_id = 0, res_valid = 0
  - ops_count = 0, busy = 0
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If ena=1 and any req_valid=1, grant one requester.
  - If only one requester is valid, grant it.
  - If both are valid, grant the one not equal to last_grant.
  - req_ready[g] is combinational, high in IDLE only for the granted requester when ena=1.
  - On the grant cycle:
    - mul_a/mul_b <= operands of g
    - res_id <= g
    - last_grant <= g
    - next state = CALC.
  - With ena=0 or no valid request, stay in IDLE with req_ready = 0.
- CALC:
  - mul_a/mul_b are stable for a full cycle.
  - res_p <= mul_p, res_valid <= 1, next state = DONE.
  - req_ready = 0.
- DONE:
  - res_valid is held; res_p and res_id are stable.
  - On res_valid & res_ready: res_valid <= 0, ops_count <= ops_count+1 (mod 2^CNT_W), next state = IDLE.
  - req_ready = 0.
- Latency: grant at cycle N gives res_valid at N+2. Peak throughput is one result per 3 cycles with res_ready tied high.
- ena=0 during CALC or DONE does not stall the in-flight operation; it only blocks the next grant.
- A requester must hold valid and operands until it sees ready. A valid dropped before grant loses no state and is not recorded.
- Asserting rst_n low mid-operation immediately returns every register to its reset value. The in-flight result is discarded and ops_count clears.
- Product width is 2W; no truncation or overflow is possible (max 15*15 = 225 for W=4).
- mul_a/mul_b keep their last value outside the grant cycle, so the multiplier does not toggle.

Test Plan:
- Reset, then req_valid=01 with a=3, b=5, res_ready=1 -> req_ready=01 at cycle 0; mul_a=3, mul_b=5 at cycle 1; res_valid=1, res_p=15, res_id=0 at cycle 2; ops_count=1.
- Both valid continuously (req0 7*9, req1 15*15), res_ready=1 -> grants alternate 0,1,0; results 63 (id 0), 225 (id 1), 63 (id 0), each 3 cycles apart.
- Backpressure: res_p=225 pending, res_ready=0 for 5 cycles -> res_valid, res_p and res_id stable; req_ready=00 throughout; ops_count unchanged until accept.
- ena=0 with req_valid=11 -> no grant, busy=0. Drop ena during CALC -> result still completes; next grant occurs only after ena returns to 1.
- Assert rst_n=0 during CALC -> res_valid=0, busy=0, mul_a=mul_b=0 asynchronously. Release reset with both valid -> requester 0 is granted first.
- Run 256 accepted operations with CNT_W=8 -> ops_count wraps 255 -> 0.
